// File: rtl/cache_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_arb_pkg
// Description : Shared state encoding and default widths for the cache
//               request arbiter and its round-robin selector.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_arb_pkg;

    localparam int C_DEF_ADDR_W = 32;
    localparam int C_DEF_LINE_W = 512;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/cache_req_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick of the first request at or
//               after a pointer, wrapping; one-hot grant plus binary index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);

    always_comb begin
        logic found;
        int   j;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_req_arbiter
// Description : Round-robin sharing of one cache CPU port between NUM_REQ
//               requesters, with saturating hit/miss statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_req_arbiter
    import cache_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int ADDR_W  = C_DEF_ADDR_W,
    parameter  int LINE_W  = C_DEF_LINE_W,
    parameter  int CNT_W   = 32,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LINE_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic                      resp_hit,
    output logic [LINE_W-1:0]         resp_rdata,
    output logic                      cache_read,
    output logic                      cache_write,
    output logic [ADDR_W-1:0]         cache_address,
    output logic [LINE_W-1:0]         cache_write_data,
    input  logic [LINE_W-1:0]         cache_read_data,
    input  logic                      cache_hit,
    input  logic                      cache_miss,
    input  logic                      cache_done,
    input  logic                      stat_clear,
    output logic [CNT_W-1:0]          hit_cnt,
    output logic [CNT_W-1:0]          miss_cnt
);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
    logic                rhit_q, rhit_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic                rd_stb_q, rd_stb_d;
    logic                wr_stb_q, wr_stb_d;
    logic                seen_q, seen_d;
    logic                hitf_q, hitf_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic                w_hit_now;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (w_gnt),
        .idx_o   (w_gnt_idx)
    );

    // A hit/miss arriving in the same cycle as done still counts; both together is a miss.
    assign w_hit_now = seen_q ? hitf_q : (cache_hit & ~cache_miss);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ack_d      = '0;
        rvalid_d   = '0;
        rhit_d     = rhit_q;
        rdata_d    = rdata_q;
        rd_stb_d   = rd_stb_q;
        wr_stb_d   = wr_stb_q;
        seen_d     = seen_q;
        hitf_d     = hitf_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    idx_d   = w_gnt_idx;
                    wr_d    = req_write[w_gnt_idx];
                    addr_d  = req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[int'(w_gnt_idx)*LINE_W +: LINE_W];
                    ack_d   = w_gnt;
                    seen_d  = 1'b0;
                    hitf_d  = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rd_stb_d = ~wr_q;
                wr_stb_d = wr_q;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (!seen_q && (cache_hit || cache_miss)) begin
                    seen_d = 1'b1;
                    hitf_d = cache_hit & ~cache_miss;
                end
                if (cache_done) begin
                    rdata_d  = cache_read_data;
                    rd_stb_d = 1'b0;
                    wr_stb_d = 1'b0;
                    rvalid_d = NUM_REQ'(1) << idx_q;
                    rhit_d   = w_hit_now;
                    if (w_hit_now) begin
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end else begin
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                rr_ptr_d = (int'(idx_q) == NUM_REQ-1) ? '0 : idx_q + IDX_W'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (stat_clear) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ack_q      <= '0;
            rvalid_q   <= '0;
            rhit_q     <= 1'b0;
            rdata_q    <= '0;
            rd_stb_q   <= 1'b0;
            wr_stb_q   <= 1'b0;
            seen_q     <= 1'b0;
            hitf_q     <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            rvalid_q   <= rvalid_d;
            rhit_q     <= rhit_d;
            rdata_q    <= rdata_d;
            rd_stb_q   <= rd_stb_d;
            wr_stb_q   <= wr_stb_d;
            seen_q     <= seen_d;
            hitf_q     <= hitf_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign req_ack          = ack_q;
    assign resp_valid       = rvalid_q;
    assign resp_hit         = rhit_q;
    assign resp_rdata       = rdata_q;
    assign cache_read       = rd_stb_q;
    assign cache_write      = wr_stb_q;
    assign cache_address    = addr_q;
    assign cache_write_data = wdata_q;
    assign hit_cnt          = hit_cnt_q;
    assign miss_cnt         = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_req_arbiter
// Description : Self-checking bench for cache_req_arbiter with a stub cache
//               and a round-robin / saturating-counter reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 512;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic            clk, rst;
    logic [N-1:0]    req_valid, req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_wdata;
    logic [N-1:0]    req_ack, resp_valid;
    logic            resp_hit;
    logic [LW-1:0]   resp_rdata;
    logic            cache_read, cache_write;
    logic [AW-1:0]   cache_address;
    logic [LW-1:0]   cache_write_data, cache_read_data;
    logic            cache_hit, cache_miss, cache_done, stat_clear;
    logic [CW-1:0]   hit_cnt, miss_cnt;

    logic [AW-1:0]   m_addr  [N];
    logic [LW-1:0]   m_wdata [N];

    int n_cmp = 0;
    int n_err = 0;
    int m_ptr = 0;
    int m_hits = 0;
    int m_miss = 0;
    int resp_per_req [N];

    cache_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .resp_valid(resp_valid),
        .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .cache_read(cache_read), .cache_write(cache_write),
        .cache_address(cache_address), .cache_write_data(cache_write_data),
        .cache_read_data(cache_read_data), .cache_hit(cache_hit),
        .cache_miss(cache_miss), .cache_done(cache_done),
        .stat_clear(stat_clear), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = m_addr[i];
            req_wdata[i*LW +: LW] = m_wdata[i];
        end
    end

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rline();
        logic [LW-1:0] r;
        for (int i = 0; i < LW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // mode: 0 hit, 1 miss, 2 hit+miss together, 3 no indication before done
    task automatic run_one(input int lat, input int mode, input int hmd,
                           input logic [LW-1:0] line, input bit keep, input bit clr);
        int e;
        bit got;
        bit w;
        bit eh;
        logic [AW-1:0] a;
        logic [LW-1:0] wd;
        logic [N-1:0]  eg;
        e   = pick(req_valid, m_ptr);
        got = 1'b0;
        for (int t = 0; t < 12 && !got; t++) begin
            @(negedge clk);
            if (|req_ack) got = 1'b1;
        end
        chk("ack_seen", LW'(got), LW'(1));
        if (!got || e < 0) return;
        eg = N'(1) << e;
        chk("ack_onehot", LW'(req_ack), LW'(eg));
        w  = req_write[e];
        a  = m_addr[e];
        wd = m_wdata[e];
        if (keep) begin
            m_addr[e]    = $urandom;
            m_wdata[e]   = rline();
            req_write[e] = 1'($urandom);
        end else begin
            req_valid[e] = 1'b0;
        end
        @(negedge clk);
        for (int c = 0; c < lat; c++) begin
            chk("strobes", LW'({cache_read, cache_write}), LW'({~w, w}));
            chk("address", LW'(cache_address), LW'(a));
            chk("wdata", cache_write_data, wd);
            cache_hit  = 1'b0;
            cache_miss = 1'b0;
            if (c == hmd) begin
                cache_hit  = (mode == 0) || (mode == 2);
                cache_miss = (mode == 1) || (mode == 2);
            end else if (c == hmd + 1 && mode != 3) begin
                cache_hit  = (mode != 0);
                cache_miss = (mode == 0);
            end
            cache_done = (c == lat - 1);
            if (c == lat - 1) begin
                cache_read_data = line;
                stat_clear      = clr;
            end else begin
                cache_read_data = rline();
            end
            if (c < lat - 1) @(negedge clk);
        end
        @(negedge clk);
        cache_hit  = 1'b0;
        cache_miss = 1'b0;
        cache_done = 1'b0;
        stat_clear = 1'b0;
        eh = (mode == 0);
        chk("release_strobes", LW'({cache_read, cache_write}), LW'(0));
        chk("resp_valid", LW'(resp_valid), LW'(eg));
        chk("resp_hit", LW'(resp_hit), LW'(eh));
        chk("resp_rdata", resp_rdata, line);
        if (clr) begin
            m_hits = 0;
            m_miss = 0;
        end else if (eh) begin
            m_hits = (m_hits < CMAX) ? m_hits + 1 : CMAX;
        end else begin
            m_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
        end
        chk("hit_cnt", LW'(hit_cnt), LW'(m_hits));
        chk("miss_cnt", LW'(miss_cnt), LW'(m_miss));
        resp_per_req[e]++;
        m_ptr = (e + 1) % N;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int hmd;
        bit got;
        rst = 1'b0;
        req_valid = '0; req_write = '0;
        cache_read_data = '0; cache_hit = 1'b0; cache_miss = 1'b0;
        cache_done = 1'b0; stat_clear = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_addr[i] = '0; m_wdata[i] = '0; resp_per_req[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ack", LW'(req_ack), LW'(0));
        chk("rst_resp", LW'(resp_valid), LW'(0));
        chk("rst_strobes", LW'({cache_read, cache_write}), LW'(0));
        chk("rst_addr", LW'(cache_address), LW'(0));
        chk("rst_cnts", LW'({hit_cnt, miss_cnt}), LW'(0));
        rst = 1'b1;
        @(negedge clk);

        // Single read miss, long latency
        m_addr[0] = 32'h1000_0040; m_wdata[0] = rline();
        req_write[0] = 1'b0; req_valid[0] = 1'b1;
        run_one(20, 1, 0, {64{8'hA5}}, 1'b0, 1'b0);

        // All requesters contending continuously, always hit
        for (int i = 0; i < N; i++) begin
            m_addr[i] = $urandom; m_wdata[i] = rline(); resp_per_req[i] = 0;
        end
        req_write = 4'b0000;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) run_one(2 + (k % 3), 0, 0, rline(), 1'b1, 1'b0);
        req_valid = '0;
        for (int i = 0; i < N; i++) chk("rr_fair", LW'(resp_per_req[i]), LW'(2));

        // Write from requester 2
        m_addr[2] = 32'h1000_0100; m_wdata[2] = rline();
        req_write[2] = 1'b1; req_valid[2] = 1'b1;
        run_one(5, 0, 1, rline(), 1'b0, 1'b0);

        // Hit and miss together
        m_addr[1] = $urandom; req_write[1] = 1'b0; req_valid[1] = 1'b1;
        run_one(4, 2, 0, rline(), 1'b0, 1'b0);

        // Reset while waiting on the cache
        m_addr[3] = $urandom; m_wdata[3] = rline();
        req_write[3] = 1'b0; req_valid[3] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 12 && !got; t++) begin
            @(negedge clk);
            if (|req_ack) got = 1'b1;
        end
        chk("rst_mid_ack_seen", LW'(got), LW'(1));
        req_valid[3] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_strobes", LW'({cache_read, cache_write}), LW'(0));
        chk("rst_mid_resp", LW'(resp_valid), LW'(0));
        chk("rst_mid_cnts", LW'({hit_cnt, miss_cnt}), LW'(0));
        chk("rst_mid_addr", LW'(cache_address), LW'(0));
        m_hits = 0; m_miss = 0; m_ptr = 0;
        @(negedge clk);
        rst = 1'b1;
        req_valid[3] = 1'b1;
        run_one(3, 0, 0, rline(), 1'b0, 1'b0);

        // Randomized contention
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < N; i++) begin
                m_addr[i] = $urandom; m_wdata[i] = rline();
            end
            req_write = 4'($urandom);
            req_valid = 4'($urandom_range(1, 15));
            lat = $urandom_range(2, 6);
            hmd = $urandom_range(0, lat - 2);
            run_one(lat, $urandom_range(0, 3), hmd, rline(), 1'b0, 1'b0);
            req_valid = '0;
        end

        // Saturation and clear priority
        @(negedge clk);
        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
        m_hits = 0; m_miss = 0;
        chk("clear_cnts", LW'({hit_cnt, miss_cnt}), LW'(0));
        req_write[0] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            m_addr[0] = $urandom;
            req_valid[0] = 1'b1;
            run_one(2, 0, 0, rline(), 1'b0, 1'b0);
        end
        chk("hit_saturated", LW'(hit_cnt), LW'(CMAX));
        req_valid[0] = 1'b1;
        run_one(2, 1, 0, rline(), 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
Shares the single cache controller port (cpu_read/cpu_write/cpu_address/cpu_write_data → cpu_read_data, cache_hit/cache_miss, done_signal) between NUM_REQ requesters. Uses round-robin arbitration. Latches the granted request, sequences the cache handshake through completion and routes the result back to the winner. Keeps saturating hit/miss statistics. Sits between the requester ports and top_level's CPU-side interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, byte address width
LINE_W, 512, cache line data width
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
req_valid  in  NUM_REQ  per-requester request pending; held until req_ack
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*LINE_W  packed write lines
req_ack  out  NUM_REQ  one-cycle pulse: request i latched
resp_valid  out  NUM_REQ  one-cycle pulse: request i completed
resp_hit  out  1  hit flag of completed access, valid with resp_valid
resp_rdata  out  LINE_W  line returned, valid with resp_valid
cache_read  out  1  to cache cpu_read
cache_write  out  1  to cache cpu_write
cache_address  out  ADDR_W  to cache cpu_address
cache_write_data  out  LINE_W  to cache cpu_write_data
cache_read_data  in  LINE_W  from cache cpu_read_data
cache_hit  in  1  from cache
cache_miss  in  1  from cache
cache_done  in  1  from cache done_signal
stat_clear  in  1  synchronous clear of counters
hit_cnt  out  CNT_W  total hits
miss_cnt  out  CNT_W  total misses

Behaviour:
- Reset (rst=0): state IDLE, rr pointer 0, all outputs 0, counters 0, latched request registers 0.
- FSM IDLE → ISSUE → WAIT → RELEASE → IDLE.
- IDLE:
  - If any req_valid, select the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch that requester's write/addr/wdata/index, pulse req_ack[idx] for one cycle, go to ISSUE.
  - Cache strobes stay 0 in IDLE.
- ISSUE: drive cache_address/cache_write_data from latches. Assert cache_read or cache_write (never both). Go to WAIT.
- WAIT:
  - Hold strobes and data stable.
  - On the first cycle cache_hit or cache_miss is 1, record hit_flag = cache_hit. Later assertions in the same access are ignored.
  - If both are 1 in the same cycle, treat it as a miss.
  - When cache_done=1: capture cache_read_data and go to RELEASE. If cache_done arrives before any hit/miss indication, record a miss.
- RELEASE:
  - Strobes 0 for exactly one cycle, which gives the cache its mandatory idle cycle between accesses.
  - Pulse resp_valid[idx] with resp_hit/resp_rdata.
  - Increment hit_cnt or miss_cnt.
  - rr_ptr = (idx+1) mod NUM_REQ. Go to IDLE.
- resp_rdata is the captured line for reads. For writes it is the captured value and carries no meaning.
- Latency: req_ack is 1 cycle after req_valid is sampled in IDLE. The cache strobe rises the cycle after req_ack. resp_valid is 1 cycle after cache_done is sampled. Best-case back-to-back issue interval is cache latency + 3 cycles.
- Requester changes to req_* after req_ack do not affect the in-flight access.
- A requester deasserting req_valid before ack is simply not granted. No ack is owed.
- Counters saturate at all-ones.
- stat_clear=1 zeroes both counters and takes priority over an increment in the same cycle.
- Reset mid-access: everything returns to reset values immediately. No resp_valid is generated for the aborted request; the requester must reissue.
- cache_done in IDLE/ISSUE/RELEASE is ignored.

Decomposition:
- Package cache_arb_pkg: FSM state encoding (IDLE, ISSUE, WAIT, RELEASE), default widths ADDR_W=32, LINE_W=512.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and rr_ptr; outputs one-hot grant and binary index. Purely combinational, reused elsewhere.

Test Plan:
1. Single requester 0 reads 0x10000040 with a stub cache that returns miss then done after 20 cycles with line 0xA5..A5 → exactly one req_ack[0]; cache_read high for the whole access; resp_valid[0] with resp_hit=0, rdata=0xA5..A5; miss_cnt=1.
2. All 4 requesters valid continuously, stub always hits → grants in order 0,1,2,3,0,1,…; after 8 accesses each requester has 2 resp_valid and hit_cnt=8.
3. Requester 2 write to 0x10000100 with random line → cache_write=1, cache_read=0; cache_address and cache_write_data equal the latched values, stable until done; strobes are 0 for one cycle in RELEASE.
4. Stub asserts cache_hit and cache_miss together, then cache_done → resp_hit=0, miss_cnt increments by 1.
5. Drop rst to 0 while in WAIT → all strobes 0 and state IDLE immediately; no resp_valid; counters 0. After release, a new request proceeds normally.
6. Preload hit_cnt to all-ones via 2^CNT_W−1 hits (use CNT_W=4: 15 hits), then one more hit → hit_cnt stays 15. stat_clear asserted in the same cycle as an increment → 0.
